dm_access_unit: RTL
===================

# dm_access_unit

Multi-cycle data-memory access unit for the rv32i core. It sits directly downstream of the control unit. It consumes `DmWr`/`DmCtrl` together with the ALU-computed address and rs2 store data, and runs a req/ack transaction on the data-memory bus. Load results are aligned and sign- or zero-extended onto `rdata`, which feeds the `RUDataWrSrc = 01` writeback input. While a transaction is outstanding, the unit stalls the core through `busy`.

## Interface
- `TIMEOUT`, 16 — max cycles in BUS waiting for `mem_ack`; 0 disables the timeout.
- `clk` in 1 — core clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `start` in 1 — load/store instruction present; inputs held stable by core until `done`.
- `dm_wr` in 1 — 1 = store, 0 = load (the control unit's `DmWr`).
- `dm_ctrl` in 3 — access width (the control unit's `DmCtrl`): 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr` in 32 — byte address (ALU result).
- `wdata` in 32 — store data (rs2).
- `rdata` out 32 — extended load result, registered.
- `busy` out 1 — core stall request.
- `done` out 1 — one-cycle completion pulse.
- `err` out 1 — qualifies `done`: misaligned access, illegal `dm_ctrl`, or timeout.
- `mem_req` out 1 — bus request, registered.
- `mem_we` out 1 — bus write.
- `mem_addr` out 32 — word address, {addr[31:2], 2'b00}.
- `mem_be` out 4 — byte enables.
- `mem_wdata` out 32 — lane-replicated store data.
- `mem_ack` in 1 — bus completion; `mem_rdata` valid in the same cycle.
- `mem_rdata` in 32 — bus read word.

## Operation
- FSM states:
  - IDLE.
  - BUS: request outstanding.
  - DONE: one-cycle completion.
- IDLE:
  - `start` with a legal, aligned access: capture `mem_addr`/`mem_be`/`mem_wdata`/`mem_we`, go to BUS.
  - `start` with an illegal or misaligned access: go to DONE with `err` = 1; no bus activity.
- Legality:
  - Loads accept dm_ctrl 000/001/010/100/101.
  - Stores accept 000/001/010.
  - Any other code is illegal.
- Alignment:
  - H/HU require addr[0] = 0.
  - W requires addr[1:0] = 00.
  - B/BU are always aligned.
- Byte enables:
  - B/BU: 4'b0001 << addr[1:0].
  - H/HU: 4'b0011 << addr[1:0].
  - W: 4'b1111.
- Store data:
  - B: {4{wdata[7:0]}}.
  - H: {2{wdata[15:0]}}.
  - W: wdata.
- BUS:
  - `mem_req` = 1 and all `mem_*` outputs stay stable until `mem_ack`.
  - On `mem_ack`: go to DONE. For a load, `rdata` is loaded with the extracted lane, `mem_rdata >> (8*addr[1:0])`:
    - B: sign-extend bit 7.
    - BU: zero-extend.
    - H: sign-extend bit 15.
    - HU: zero-extend.
    - W: full word.
  - Stores leave `rdata` unchanged.
- Timeout:
  - The wait counter counts cycles in BUS without `mem_ack`.
  - When it reaches `TIMEOUT`: drop `mem_req`, go to DONE with `err` = 1, and set `rdata` = 0 for loads.
- DONE:
  - `done` = 1, `err` valid, `busy` = 0.
  - Next state is IDLE unconditionally.
  - `start` arriving in DONE is ignored; the core is advancing in this cycle.
- `start` while in BUS is ignored; it is already the held request.
- `mem_ack` in IDLE or DONE is a spurious ack: ignored, no state change.

## Timing
- `busy` is combinational: (IDLE & `start`) | BUS. It rises in the same cycle as `start`, so a single-cycle core stalls immediately.
- Minimum legal access latency:
  - `start` in cycle 0.
  - `mem_req` high in cycle 1.
  - `mem_ack` in cycle 1.
  - `done` in cycle 2, with `rdata` valid from cycle 2.
- Each wait cycle before `mem_ack` adds one cycle of latency.
- Error path: `start` in cycle 0 → `done` & `err` in cycle 1; `mem_req` never asserts.
- Timeout path:
  - With `TIMEOUT` = N, the last cycle of `mem_req` is cycle N.
  - `done` & `err` assert in cycle N+1.
- Reset values (asynchronous `rst_n` low):
  - State IDLE.
  - `mem_req`, `mem_we`, `done`, `err` = 0.
  - `mem_addr`, `mem_be`, `mem_wdata`, `rdata` = 0.
  - Wait counter = 0.
- Reset asserted mid-BUS drops `mem_req` immediately, with no `done` pulse. The bus must tolerate the abandoned request.
- Wait counter:
  - Width $clog2(TIMEOUT+1).
  - Clears on entry to BUS.
  - Saturates; it never wraps.
- `err` is meaningful only when `done` = 1; it is 0 otherwise.

## Test plan
- LW at addr 0x100, `mem_ack` in cycle 1 with `mem_rdata` 0xDEADBEEF → `mem_be` 1111, `mem_addr` 0x100, `done` in cycle 2, `rdata` 0xDEADBEEF, `err` 0.
- LB at 0x103, `mem_rdata` 0x80FF_0000 → `mem_be` 1000, `rdata` 0xFFFFFF80. LBU at the same address → `rdata` 0x00000080. LHU at 0x102 → `rdata` 0x000080FF.
- SB at 0x201 with `wdata` 0x12345678, ack after 3 wait cycles → `mem_we` 1, `mem_be` 0010, `mem_wdata` 0x78787878, `busy` high 5 cycles, `done` without `err`, `rdata` unchanged.
- SW at 0x202, LH at 0x001, and load with `dm_ctrl` 011 → each gives `done` & `err` in cycle 1 with `mem_req` never high.
- `TIMEOUT` = 4 with no `mem_ack` → `mem_req` high in cycles 1–4, then `done` & `err` in cycle 5, `rdata` 0.
- `rst_n` low during BUS, plus spurious `mem_ack` in IDLE → immediate return to IDLE, all outputs 0, no `done`.

Source files
------------

// File: rtl/dm_access_unit.sv
// Multi-cycle data-memory access unit: decodes width/alignment, runs one req/ack bus
// transaction per load/store and returns the aligned, extended load data on rdata.
module dm_access_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        dm_wr,
    input  logic [2:0]  dm_ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    // A zero TIMEOUT still needs a 1-bit counter so the declarations stay legal.
    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic [1:0]        off_q, off_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              legal;
    logic              aligned;
    logic [3:0]        be_new;
    logic [31:0]       wdata_new;
    logic [31:0]       lane;
    logic [31:0]       load_ext;
    logic              timeout;

    // Request decode from the live core inputs (only used in IDLE).
    always_comb begin
        legal     = 1'b0;
        aligned   = 1'b1;
        be_new    = 4'b1111;
        wdata_new = wdata;
        case (dm_ctrl)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !dm_wr;
            default:                legal = 1'b0;
        endcase
        case (dm_ctrl[1:0])
            2'b00: begin
                be_new    = 4'b0001 << addr[1:0];
                wdata_new = {4{wdata[7:0]}};
            end
            2'b01: begin
                aligned   = !addr[0];
                be_new    = 4'b0011 << addr[1:0];
                wdata_new = {2{wdata[15:0]}};
            end
            2'b10: begin
                aligned   = (addr[1:0] == 2'b00);
            end
            default: begin
                aligned   = 1'b1;
            end
        endcase
    end

    // Load lane extraction from the captured width and byte offset.
    always_comb begin
        lane = mem_rdata >> {off_q, 3'b000};
        case (ctrl_q)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b100:  load_ext = {24'b0, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b101:  load_ext = {16'b0, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    assign timeout = (TIMEOUT != 0) && (cnt_q == CntLast);

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        ctrl_d      = ctrl_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        busy        = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy = start;
                if (start) begin
                    if (legal && aligned) begin
                        state_d     = StBus;
                        mem_req_d   = 1'b1;
                        mem_we_d    = dm_wr;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_be_d    = be_new;
                        mem_wdata_d = wdata_new;
                        ctrl_d      = dm_ctrl;
                        off_d       = addr[1:0];
                        cnt_d       = '0;
                    end else begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end
                end
            end
            StBus: begin
                busy = 1'b1;
                if (mem_ack) begin
                    state_d   = StDone;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        rdata_d = load_ext;
                    end
                end else if (timeout) begin
                    state_d   = StDone;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (!mem_we_q) begin
                        rdata_d = '0;
                    end
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                err_d   = 1'b0;
            end
            default: begin
                state_d   = StIdle;
                mem_req_d = 1'b0;
                err_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            ctrl_q      <= '0;
            off_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            ctrl_q      <= ctrl_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
        end
    end

    assign done      = (state_q == StDone);
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule
